// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU definitions: word size, opcode constants, FSM state encoding
// and the latched-instruction payload used by the execute unit.
package alu_exec_unit_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned REG_IDX_W = 2;
  localparam int unsigned NUM_REGS  = 4;

  typedef logic [WORD_SIZE-1:0] word_t;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b1101;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1110;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1100;
  localparam logic [OP_W-1:0] OP_ALS = 4'b0101;
  localparam logic [OP_W-1:0] OP_ARS = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EX   = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Instruction captured when leaving IDLE; operands are already resolved
  // so later changes to the select inputs or register file cannot leak in.
  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic                 carry;
    logic                 write_en;
    logic [REG_IDX_W-1:0] rd;
    word_t                a;
    word_t                b;
  } instr_t;

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Combinational ALU datapath.
// Ports: a, b (operands), op (opcode), carry (carry-in for ADD/NOT),
//        result, overflow (signed overflow on ADD/SUB), illegal (unknown op).
module alu_core
  import alu_exec_unit_pkg::*;
(
  input  word_t           a,
  input  word_t           b,
  input  logic [OP_W-1:0] op,
  input  logic            carry,
  output word_t           result,
  output logic            overflow,
  output logic            illegal
);

  localparam int unsigned MSB = WORD_SIZE - 1;

  // Opcode decode and arithmetic; unknown codes yield zero and flag illegal.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD: begin
        result   = a + b + WORD_SIZE'(carry);
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result   = a - b;
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a + WORD_SIZE'(carry);
      OP_ALS:  result = {a[MSB-1:0], 1'b0};
      OP_ARS:  result = {a[MSB], a[MSB:1]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Three-state ALU execute unit with a 4-entry register file.
// Ports: clk, reset_n; start + instruction fields (alu_op, carry, alu_src_a,
//        alu_src_b, pvs_write_en, rs, rt, rd, pc_in, imm); busy, done,
//        result, overflow, zero, illegal; dbg_sel/dbg_data register peek.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      alu_op,
  input  logic                 carry,
  input  logic [1:0]           alu_src_a,
  input  logic [1:0]           alu_src_b,
  input  logic                 pvs_write_en,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [REG_IDX_W-1:0] rt,
  input  logic [REG_IDX_W-1:0] rd,
  input  word_t                pc_in,
  input  word_t                imm,
  output logic                 busy,
  output logic                 done,
  output word_t                result,
  output logic                 overflow,
  output logic                 zero,
  output logic                 illegal,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output word_t                dbg_data
);

  state_e state_q, state_d;
  logic   busy_d, done_d;
  logic   latch_en, capture_en, wb_en;
  instr_t instr_q;
  word_t  regs_q [NUM_REGS];
  word_t  op_a, op_b;
  word_t  core_result;
  logic   core_overflow, core_illegal;

  // Operand selection from the pre-edge register file contents.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (alu_src_a)
      2'd0:    op_a = regs_q[rs];
      2'd1:    op_a = pc_in;
      default: op_a = '0;
    endcase
    case (alu_src_b)
      2'd0:    op_b = regs_q[rt];
      2'd1:    op_b = imm;
      2'd2:    op_b = WORD_SIZE'(1);
      default: op_b = '0;
    endcase
  end

  alu_core u_alu_core (
    .a        (instr_q.a),
    .b        (instr_q.b),
    .op       (instr_q.op),
    .carry    (instr_q.carry),
    .result   (core_result),
    .overflow (core_overflow),
    .illegal  (core_illegal)
  );

  // Next-state and stage strobes.
  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    wb_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_EX;
          latch_en = 1'b1;
        end
      end
      ST_EX: begin
        state_d    = ST_WB;
        capture_en = 1'b1;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        wb_en   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_WB);
  end

  // State and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Instruction capture on IDLE->EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0;
    end else if (latch_en) begin
      instr_q <= '{op: alu_op, carry: carry, write_en: pvs_write_en,
                   rd: rd, a: op_a, b: op_b};
    end
  end

  // Result flags captured on EX->WB, held until the next instruction's EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else if (capture_en) begin
      result   <= core_result;
      overflow <= core_overflow;
      zero     <= (core_result == '0);
      illegal  <= core_illegal;
    end
  end

  // Register file write-back on WB->IDLE; illegal ops never write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_en && instr_q.write_en && !illegal) begin
      regs_q[instr_q.rd] <= result;
    end
  end

  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  typedef struct {
    logic [3:0]  op;
    logic        carry;
    logic [1:0]  sa, sb, rs, rt, rd;
    logic        we;
    logic [15:0] pc, imm;
    logic [15:0] exp_res;
    logic        exp_ov, exp_z, exp_ill;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ov, z, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  alu_op;
  logic        carry;
  logic [1:0]  alu_src_a, alu_src_b;
  logic        pvs_write_en;
  logic [1:0]  rs, rt, rd;
  logic [15:0] pc_in, imm;
  logic        busy, done;
  logic [15:0] result;
  logic        overflow, zero, illegal;
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [15:0] model [4];
  vec_t vecs [16];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alu_op(alu_op), .carry(carry),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pvs_write_en(pvs_write_en),
    .rs(rs), .rt(rt), .rd(rd), .pc_in(pc_in), .imm(imm),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .zero(zero), .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic c, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [1:0] rs_i, input logic [1:0] rt_i,
                              input logic [1:0] rd_i, input logic we, input logic [15:0] pc,
                              input logic [15:0] im, input logic [15:0] er, input logic eo,
                              input logic ez, input logic ei);
    vec_t v;
    v.op = op; v.carry = c; v.sa = sa; v.sb = sb; v.rs = rs_i; v.rt = rt_i; v.rd = rd_i;
    v.we = we; v.pc = pc; v.imm = im; v.exp_res = er; v.exp_ov = eo; v.exp_z = ez; v.exp_ill = ei;
    return v;
  endfunction

  // Scoreboard: compare registered outputs while done is high.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("overflow", 16'(overflow), 16'(e.ov));
        chk("zero", 16'(zero), 16'(e.z));
        chk("illegal", 16'(illegal), 16'(e.ill));
      end
    end
  end

  task automatic drive(input vec_t v);
    exp_t e;
    alu_op = v.op; carry = v.carry; alu_src_a = v.sa; alu_src_b = v.sb;
    rs = v.rs; rt = v.rt; rd = v.rd; pvs_write_en = v.we; pc_in = v.pc; imm = v.imm;
    start = 1'b1;
    e.res = v.exp_res; e.ov = v.exp_ov; e.z = v.exp_z; e.ill = v.exp_ill;
    exp_q.push_back(e);
  endtask

  task automatic scramble();
    alu_op = 4'($urandom); carry = 1'($urandom); alu_src_a = 2'($urandom);
    alu_src_b = 2'($urandom); rs = 2'($urandom); rt = 2'($urandom); rd = 2'($urandom);
    pvs_write_en = 1'($urandom); pc_in = 16'($urandom); imm = 16'($urandom);
  endtask

  // Issue one instruction from IDLE and follow it to completion.
  task automatic issue(input vec_t v, input bit pulse_ex);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    start = pulse_ex;
    scramble();
    chk("busy_ex", 16'(busy), 16'd1);
    chk("done_ex", 16'(done), 16'd0);
    @(negedge clk);
    start = 1'b0;
    chk("done_wb", 16'(done), 16'd1);
    chk("busy_wb", 16'(busy), 16'd1);
    @(negedge clk);
    chk("done_idle", 16'(done), 16'd0);
    chk("busy_idle", 16'(busy), 16'd0);
    if (v.we && !v.exp_ill) model[v.rd] = v.exp_res;
    dbg_sel = v.rd;
    #1 chk("regfile", dbg_data, model[v.rd]);
  endtask

  task automatic check_reset_state();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_zero", 16'(zero), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk("rst_reg", dbg_data, 16'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t abort_v;
    reset_n = 1'b0; start = 1'b0; dbg_sel = 2'd0;
    alu_op = '0; carry = 1'b0; alu_src_a = '0; alu_src_b = '0; pvs_write_en = 1'b0;
    rs = '0; rt = '0; rd = '0; pc_in = '0; imm = '0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;

    //            op       c  sa sb rs rt rd we pc        imm       res       ov z  ill
    vecs[0]  = mk(4'b0000, 0, 1, 1, 0, 0, 2, 1, 16'h0005, 16'h0003, 16'h0008, 0, 0, 0);
    vecs[1]  = mk(4'b0000, 0, 0, 2, 2, 0, 1, 1, 16'hAAAA, 16'h5555, 16'h0009, 0, 0, 0);
    vecs[2]  = mk(4'b0000, 0, 1, 1, 0, 0, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0);
    vecs[3]  = mk(4'b0001, 0, 1, 1, 0, 0, 3, 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0);
    vecs[4]  = mk(4'b1100, 1, 1, 1, 0, 0, 0, 0, 16'h0005, 16'h1111, 16'hFFFB, 0, 0, 0);
    vecs[5]  = mk(4'b1100, 0, 1, 1, 0, 0, 0, 0, 16'h0005, 16'h1111, 16'hFFFA, 0, 0, 0);
    vecs[6]  = mk(4'b1101, 0, 1, 1, 0, 0, 0, 0, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0);
    vecs[7]  = mk(4'b1110, 0, 1, 1, 0, 0, 0, 0, 16'hF0F0, 16'h0FF0, 16'hFFF0, 0, 0, 0);
    vecs[8]  = mk(4'b0101, 0, 1, 1, 0, 0, 0, 0, 16'hC001, 16'h0000, 16'h8002, 0, 0, 0);
    vecs[9]  = mk(4'b0100, 0, 1, 1, 0, 0, 0, 0, 16'h8004, 16'h0000, 16'hC002, 0, 0, 0);
    vecs[10] = mk(4'b0100, 0, 1, 1, 0, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 0, 1, 0);
    vecs[11] = mk(4'b1010, 0, 1, 1, 0, 0, 2, 1, 16'h1234, 16'h1111, 16'h0000, 0, 1, 1);
    vecs[12] = mk(4'b0001, 1, 1, 1, 0, 0, 0, 0, 16'h0005, 16'h0005, 16'h0000, 0, 1, 0);
    vecs[13] = mk(4'b0000, 1, 2, 3, 0, 0, 0, 0, 16'h1234, 16'h4321, 16'h0001, 0, 0, 0);
    vecs[14] = mk(4'b0001, 0, 0, 0, 3, 1, 0, 1, 16'h0000, 16'h0000, 16'h7FF6, 0, 0, 0);
    vecs[15] = mk(4'b1101, 1, 1, 1, 0, 0, 0, 1, 16'hFFFF, 16'h00FF, 16'h00FF, 0, 0, 0);

    repeat (2) @(negedge clk);
    check_reset_state();
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back issue through the vector table.
    for (int i = 0; i < 16; i++) issue(vecs[i], 1'b0);

    // start pulsed during EX must not launch a second instruction.
    issue(mk(4'b1110, 0, 1, 1, 0, 0, 3, 1, 16'h0101, 16'h1010, 16'h1111, 0, 0, 0), 1'b1);
    @(negedge clk);
    chk("ex_start_ignored_busy", 16'(busy), 16'd0);
    chk("ex_start_ignored_done", 16'(done), 16'd0);

    // Reset while in WB: no write, outputs cleared, wait for a new start.
    abort_v = mk(4'b0000, 0, 1, 1, 0, 0, 1, 1, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0);
    drive(abort_v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_in_wb", 16'(done), 16'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 16'(busy), 16'd0);

    issue(vecs[0], 1'b0);
    dbg_sel = 2'd1;
    #1 chk("abort_no_write", dbg_data, 16'h0000);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
